// File: rtl/fir_mac_seq_if.sv
// Sample/coefficient/result bundle for fir_mac_seq.
// master drives samples and coefficients; slave is the filter.
interface fir_mac_seq_if #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 8,
  parameter int CHANNELS   = 2
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(TAPS);

  logic                         in_valid;
  logic                         in_ready;
  logic [CW-1:0]                in_chan;
  logic signed [WIDTH-1:0]      in_data;
  logic                         coef_we;
  logic [AW-1:0]                coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic                         out_valid;
  logic [CW-1:0]                out_chan;
  logic signed [WIDTH-1:0]      out_data;
  logic                         chan_err;

  modport master (
    output in_valid, in_chan, in_data, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_chan, out_data, chan_err
  );

  modport slave (
    input  in_valid, in_chan, in_data, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_chan, out_data, chan_err
  );
endinterface

// File: rtl/fir_mac_seq.sv
// Multi-channel FIR filter with one shared multiplier: one tap per clock,
// then a rounded, shifted and saturated result.
module fir_mac_seq #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 8,
  parameter int CHANNELS   = 2,
  parameter int SHIFT      = 15
) (
  input logic          clk,
  input logic          reset,
  fir_mac_seq_if.slave bus
);
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW    = $clog2(TAPS);
  localparam int PW    = WIDTH + COEF_WIDTH;
  localparam int ACC_W = PW + AW;

  localparam logic [AW-1:0]        K_LAST  = AW'(TAPS - 1);
  localparam logic [CW:0]          CH_LIM  = (CW + 1)'(CHANNELS);
  localparam logic signed [ACC_W:0] RND    = (SHIFT > 0) ?
      ((ACC_W + 1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic signed [WIDTH-1:0]      r_dline [CHANNELS][TAPS];
  logic signed [COEF_WIDTH-1:0] r_coef  [TAPS];
  logic signed [ACC_W-1:0]      r_acc;
  logic [AW-1:0]                r_k;
  logic [CW-1:0]                r_chan;
  logic                         r_out_valid;
  logic [CW-1:0]                r_out_chan;
  logic signed [WIDTH-1:0]      r_out_data;
  logic                         r_chan_err;

  logic                         w_chan_ok;
  logic                         w_accept;
  logic signed [PW-1:0]         w_prod;
  logic signed [ACC_W:0]        w_round;
  logic signed [ACC_W:0]        w_shift;
  logic signed [WIDTH-1:0]      w_sat;

  assign w_chan_ok     = ({1'b0, bus.in_chan} < CH_LIM);
  assign w_accept      = (r_state == IDLE) && bus.in_valid && w_chan_ok;
  assign bus.in_ready  = (r_state == IDLE) && reset;
  assign bus.out_valid = r_out_valid;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_data  = r_out_data;
  assign bus.chan_err  = r_chan_err;

  assign w_prod = r_coef[r_k] * r_dline[r_chan][r_k];

  // One guard bit above the accumulator keeps the rounding add exact.
  always_comb begin
    w_round = {r_acc[ACC_W-1], r_acc} + RND;
    w_shift = w_round >>> SHIFT;
    if (w_shift > SAT_MAX)      w_sat = SAT_MAX[WIDTH-1:0];
    else if (w_shift < SAT_MIN) w_sat = SAT_MIN[WIDTH-1:0];
    else                        w_sat = w_shift[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = MAC;
      MAC:     if (r_k == K_LAST) w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++)
        for (int unsigned t = 0; t < TAPS; t++)
          r_dline[c][t] <= '0;
      for (int unsigned t = 0; t < TAPS; t++)
        r_coef[t] <= '0;
      r_acc       <= '0;
      r_k         <= '0;
      r_chan      <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_out_data  <= '0;
      r_chan_err  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_chan_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          // The write lands at this edge, so a sample accepted alongside it
          // already multiplies against the new coefficient.
          if (bus.coef_we) r_coef[bus.coef_addr] <= bus.coef_data;
          if (bus.in_valid) begin
            if (w_chan_ok) begin
              for (int unsigned t = TAPS - 1; t > 0; t--)
                r_dline[bus.in_chan][AW'(t)] <= r_dline[bus.in_chan][AW'(t - 1)];
              r_dline[bus.in_chan][0] <= bus.in_data;
              r_acc  <= '0;
              r_k    <= '0;
              r_chan <= bus.in_chan;
            end else begin
              r_chan_err <= 1'b1;
            end
          end
        end
        MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          if (r_k != K_LAST) r_k <= r_k + 1'b1;
        end
        OUT: begin
          r_out_data  <= w_sat;
          r_out_chan  <= r_chan;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_seq.sv
// Drives two filters (SHIFT=0 and SHIFT=15) with shared stimulus and checks
// each result against hand-computed values.
module tb_fir_mac_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              tv_valid;
  logic [1:0]        tv_chan;
  logic signed [15:0] tv_data;
  logic              tv_we;
  logic [2:0]        tv_addr;
  logic signed [15:0] tv_cdata;

  fir_mac_seq_if #(.WIDTH(16), .COEF_WIDTH(16), .TAPS(8), .CHANNELS(3)) if0 ();
  fir_mac_seq_if #(.WIDTH(16), .COEF_WIDTH(16), .TAPS(8), .CHANNELS(3)) if1 ();

  assign if0.in_valid  = tv_valid;
  assign if0.in_chan   = tv_chan;
  assign if0.in_data   = tv_data;
  assign if0.coef_we   = tv_we;
  assign if0.coef_addr = tv_addr;
  assign if0.coef_data = tv_cdata;
  assign if1.in_valid  = tv_valid;
  assign if1.in_chan   = tv_chan;
  assign if1.in_data   = tv_data;
  assign if1.coef_we   = tv_we;
  assign if1.coef_addr = tv_addr;
  assign if1.coef_data = tv_cdata;

  fir_mac_seq #(.WIDTH(16), .COEF_WIDTH(16), .TAPS(8), .CHANNELS(3), .SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  fir_mac_seq #(.WIDTH(16), .COEF_WIDTH(16), .TAPS(8), .CHANNELS(3), .SHIFT(15)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  typedef struct {
    logic [1:0]         ch;
    logic signed [15:0] d;
    logic signed [15:0] e0;
    logic signed [15:0] e1;
  } vec_t;

  vec_t vq[$];
  int n_pass  = 0;
  int n_total = 0;
  int last_ov = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic send(input string nm, input logic [1:0] ch, input logic signed [15:0] d,
                      input logic signed [15:0] e0, input logic signed [15:0] e1,
                      input logic wr, input logic signed [15:0] wd, input bit mac_wr);
    int c0;
    @(negedge clk);
    chk({nm, ".ready"}, {if0.in_ready, if1.in_ready}, 2'b11);
    tv_valid = 1'b1; tv_chan = ch; tv_data = d;
    tv_we = wr; tv_addr = 3'd0; tv_cdata = wd;
    @(posedge clk); #1;
    c0 = cyc;
    tv_valid = 1'b0; tv_we = 1'b0;
    if (mac_wr) begin
      @(negedge clk);
      tv_we = 1'b1; tv_addr = 3'd7; tv_cdata = 16'sd100;
      @(negedge clk);
      tv_we = 1'b0;
    end
    while (!if0.out_valid && (cyc - c0) < 20) begin
      @(posedge clk); #1;
    end
    chk({nm, ".latency"}, cyc - c0, 9);
    chk({nm, ".ov1"}, if1.out_valid, 1);
    chk({nm, ".data0"}, if0.out_data, e0);
    chk({nm, ".data1"}, if1.out_data, e1);
    chk({nm, ".chan"}, {if0.out_chan, if1.out_chan}, {ch, ch});
    last_ov = cyc;
  endtask

  task automatic run_table(input string tag, input bit spacing);
    int prev;
    prev = 0;
    for (int i = 0; i < vq.size(); i++) begin
      send($sformatf("%s[%0d]", tag, i), vq[i].ch, vq[i].d, vq[i].e0, vq[i].e1, 1'b0, 16'sd0, 1'b0);
      if (spacing && i > 0) chk($sformatf("%s[%0d].spacing", tag, i), last_ov - prev, 10);
      prev = last_ov;
    end
  endtask

  task automatic load_coefs(input bit ramp, input logic signed [15:0] v);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tv_we = 1'b1; tv_addr = 3'(k);
      tv_cdata = ramp ? 16'(k + 1) : v;
    end
    @(negedge clk);
    tv_we = 1'b0;
  endtask

  task automatic count_no_ov(input string nm, input int ncyc);
    int n_ov;
    n_ov = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (if0.out_valid || if1.out_valid) n_ov++;
    end
    chk(nm, n_ov, 0);
  endtask

  initial begin
    reset = 1'b0;
    tv_valid = 1'b0; tv_chan = '0; tv_data = '0;
    tv_we = 1'b0; tv_addr = '0; tv_cdata = '0;

    repeat (2) @(negedge clk);
    chk("rst.in_ready", {if0.in_ready, if1.in_ready}, 0);
    chk("rst.out_valid", {if0.out_valid, if1.out_valid}, 0);
    chk("rst.out_data", {if0.out_data, if1.out_data}, 0);
    chk("rst.out_chan", {if0.out_chan, if1.out_chan}, 0);
    chk("rst.chan_err", {if0.chan_err, if1.chan_err}, 0);
    reset = 1'b1;
    #1;
    chk("rst.ready_rise", {if0.in_ready, if1.in_ready}, 2'b11);

    // Impulse through ramp coefficients, back to back.
    load_coefs(1'b1, 16'sd0);
    vq = {};
    vq.push_back('{2'd0, 16'sd100, 16'sd100, 16'sd0});
    for (int n = 1; n < 10; n++)
      vq.push_back('{2'd0, 16'sd0, (n < 8) ? 16'(100 * (n + 1)) : 16'sd0, 16'sd0});
    run_table("imp", 1'b1);

    // Channel 0 impulse interleaved with channel 1 zeros.
    vq = {};
    for (int n = 0; n < 10; n++) begin
      vq.push_back('{2'd0, (n == 0) ? 16'sd100 : 16'sd0,
                     (n < 8) ? 16'(100 * (n + 1)) : 16'sd0, 16'sd0});
      vq.push_back('{2'd1, 16'sd0, 16'sd0, 16'sd0});
    end
    run_table("ilv", 1'b0);

    // Step of 800 with half-scale coefficients.
    load_coefs(1'b0, 16'sd16384);
    vq = {};
    for (int n = 0; n < 10; n++)
      vq.push_back('{2'd1, 16'sd800, 16'sd32767, (n < 8) ? 16'(400 * (n + 1)) : 16'sd3200});
    run_table("step", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold.ov", {if0.out_valid, if1.out_valid}, 0);
    chk("hold.data1", if1.out_data, 3200);
    chk("hold.chan", {if0.out_chan, if1.out_chan}, 4'b0101);

    // Full-scale saturation, positive then negative.
    load_coefs(1'b0, 16'sd32767);
    vq = {};
    for (int n = 0; n < 8; n++)
      vq.push_back('{2'd0, 16'sd32767, 16'sd32767, (n == 0) ? 16'sd32766 : 16'sd32767});
    for (int j = 1; j <= 8; j++)
      vq.push_back('{2'd0, -16'sd32768, (j < 4) ? 16'sd32767 : -16'sd32768,
                     (j < 4) ? 16'sd32767 : ((j == 4) ? -16'sd4 : -16'sd32768)});
    run_table("sat", 1'b0);

    // Out-of-range channel is dropped with a one-cycle error pulse.
    @(negedge clk);
    tv_valid = 1'b1; tv_chan = 2'd3; tv_data = 16'sd500;
    @(posedge clk); #1;
    tv_valid = 1'b0;
    chk("err.pulse", {if0.chan_err, if1.chan_err}, 2'b11);
    chk("err.ready", {if0.in_ready, if1.in_ready}, 2'b11);
    @(posedge clk); #1;
    chk("err.clear", {if0.chan_err, if1.chan_err}, 0);
    count_no_ov("err.no_ov", 12);

    // Coefficient write during MAC is ignored; a write with acceptance applies.
    load_coefs(1'b0, 16'sd1);
    send("macw.a", 2'd1, 16'sd0, 16'sd5600, 16'sd0, 1'b0, 16'sd0, 1'b1);
    send("macw.b", 2'd1, 16'sd0, 16'sd4800, 16'sd0, 1'b0, 16'sd0, 1'b0);
    send("same.c", 2'd1, 16'sd1000, 16'sd6000, 16'sd0, 1'b1, 16'sd2, 1'b0);

    // Reset in the middle of a MAC.
    @(negedge clk);
    tv_valid = 1'b1; tv_chan = 2'd0; tv_data = 16'sd100;
    @(posedge clk); #1;
    tv_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst.in_ready", {if0.in_ready, if1.in_ready}, 0);
    chk("mrst.out_data", {if0.out_data, if1.out_data}, 0);
    @(negedge clk);
    reset = 1'b1;
    count_no_ov("mrst.no_ov", 15);
    send("mrst.imp", 2'd0, 16'sd100, 16'sd0, 16'sd0, 1'b0, 16'sd0, 1'b0);
    load_coefs(1'b0, 16'sd1);
    send("mrst.ch1", 2'd1, 16'sd0, 16'sd0, 16'sd0, 1'b0, 16'sd0, 1'b0);
    send("mrst.ch0", 2'd0, 16'sd0, 16'sd100, 16'sd0, 1'b0, 16'sd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fir_mac_seq.md
FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

Interface
REQ-001 Parameter WIDTH, 16, signed sample width for input and output.
REQ-002 Parameter COEF_WIDTH, 16, signed coefficient width.
REQ-003 Parameter TAPS, 8, filter length, minimum 2.
REQ-004 Parameter CHANNELS, 2, independent delay lines, minimum 1.
REQ-005 Parameter SHIFT, 15, arithmetic right shift applied to the accumulator before output.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low; low means in reset.
REQ-008 in_valid  in  1  input sample offered.
REQ-009 in_ready  out  1  block can accept a sample.
REQ-010 in_chan  in  max(1,clog2(CHANNELS))  channel of offered sample.
REQ-011 in_data  in  WIDTH  signed sample.
REQ-012 coef_we  in  1  coefficient write strobe.
REQ-013 coef_addr  in  clog2(TAPS)  tap index to write.
REQ-014 coef_data  in  COEF_WIDTH  signed coefficient.
REQ-015 out_valid  out  1  one-cycle result strobe.
REQ-016 out_chan  out  same width as in_chan  channel of result.
REQ-017 out_data  out  WIDTH  signed filtered result, held until next result.
REQ-018 chan_err  out  1  one-cycle pulse: sample rejected for in_chan >= CHANNELS.

Function
REQ-019 One shared multiplier; one coefficient-by-sample product per clock.
REQ-020 FSM states IDLE, MAC, OUT; in_ready SHALL be 1 only in IDLE with reset high.
REQ-021 IDLE: on in_valid and in_ready at a rising edge, with in_chan valid, shift in_data into position 0 of that channel's delay line (older samples move up one, oldest discarded), clear accumulator and tap index, latch channel, go to MAC.
REQ-022 IDLE: on an accepted sample with in_chan >= CHANNELS, drop it, pulse chan_err the next cycle, stay in IDLE, change no delay line.
REQ-023 MAC: tap k = 0..TAPS-1 over TAPS consecutive cycles, acc += coef[k] * x[chan][k], where x[chan][0] is the newest sample; after k = TAPS-1 go to OUT.
REQ-024 Accumulator width SHALL be WIDTH+COEF_WIDTH+clog2(TAPS), signed, with no overflow possible.
REQ-025 OUT: out_data = saturate_WIDTH((acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT); out_chan = latched channel; out_valid = 1 for exactly this cycle; next state IDLE.
REQ-026 Saturation SHALL clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-027 Latency: sample accepted at edge E0 gives out_valid high in the cycle after edge E0+TAPS+1; throughput one sample per TAPS+2 cycles.
REQ-028 Coefficient write takes effect at the edge where coef_we=1 in IDLE; writes in MAC or OUT SHALL be ignored.
REQ-029 A coefficient write and sample acceptance in the same IDLE cycle: the write applies first, so the MAC for that sample uses the new coefficient.
REQ-030 Channels SHALL be fully isolated; a sample on one channel never changes another channel's delay line or results.

Reset
REQ-031 reset low: state IDLE, all delay lines 0, all coefficients 0, accumulator 0, out_valid 0, out_data 0, out_chan 0, chan_err 0, in_ready 0.
REQ-032 Reset asserted in MAC or OUT aborts the computation; no out_valid is produced for it.
REQ-033 in_ready SHALL rise in the first cycle after reset deasserts.

Verification
REQ-034 SHIFT=0, coef[k]=k+1; send impulse 100 then 9 zeros on chan 0 -> out_data 100,200,...,800,0,0; out_chan 0; out_valid spacing 10 cycles.
REQ-035 Defaults, all coefs 16384; step 800 on chan 1 for 10 samples -> out_data 400,800,...,3200,3200,3200.
REQ-036 SHIFT=0, all coefs 32767; 8 samples of 32767 -> out_data saturates to 32767; all -32768 -> -32768.
REQ-037 Interleave chan 0 impulse and chan 1 zeros -> chan 1 outputs all 0; chan 0 sequence identical to REQ-034.
REQ-038 in_chan=2 with CHANNELS=2 -> chan_err one-cycle pulse, no out_valid, in_ready stays 1; a coef_we during MAC -> the next result uses the old coefficient.
REQ-039 reset pulsed low mid-MAC -> no out_valid, out_data 0, next impulse response starts from cleared delay lines with coefficients 0, so output is 0.
